// File: rtl/rom_load_ctrl_if.sv
// HPS ioctl download bus between hps_io and the ROM loader.
// master = hps_io side, slave = rom_load_ctrl side.
interface rom_load_ctrl_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output ioctl_wait
    );
endinterface

// File: rtl/rom_load_ctrl.sv
// ROM loader: writes ioctl downloads into BIOS/cart RAM, pads the cart,
// holds BALLY in reset, then maps CPU cart reads with mirroring.
// Ports: clk_sys, reset_l, ioctl (slave), cpu_*_addr in,
// cart/bios RAM addr/data/we out, cart_size, cart_present, sys_reset_l.
module rom_load_ctrl #(
    parameter int         AW          = 13,
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         HOLD_CYCLES = 16,
    parameter logic [7:0] BIOS_INDEX  = 8'd0,
    parameter logic [7:0] CART_INDEX  = 8'd1
) (
    input  logic          clk_sys,
    input  logic          reset_l,
    rom_load_ctrl_if.slave ioctl,
    input  logic [AW-1:0] cpu_cart_addr,
    input  logic [AW-1:0] cpu_bios_addr,
    output logic [AW-1:0] cart_ram_addr,
    output logic [7:0]    cart_ram_data,
    output logic          cart_ram_we,
    output logic [AW-1:0] bios_ram_addr,
    output logic [7:0]    bios_ram_data,
    output logic          bios_ram_we,
    output logic [AW:0]   cart_size,
    output logic          cart_present,
    output logic          sys_reset_l
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] QTR  = FULL >> 2;
    localparam logic [AW:0] HALF = FULL >> 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_FILL,
        S_HOLD,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic          dl_q;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   size_q, size_d;
    logic          present_q, present_d;
    logic [AW-1:0] mask_q, mask_d;
    logic          run_q, wait_q;
    logic          c_we_q, c_we_d;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic [7:0]    c_data_q, c_data_d;
    logic          b_we_q, b_we_d;
    logic [AW-1:0] b_addr_q, b_addr_d;
    logic [7:0]    b_data_q, b_data_d;

    logic          dl_rise, dl_fall;
    logic          in_range, is_cart, is_bios;
    logic [AW:0]   wr_size;

    assign dl_rise  = ioctl.ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl.ioctl_download & dl_q;
    assign in_range = (ioctl.ioctl_addr[24:AW] == '0);
    assign is_cart  = (idx_q == CART_INDEX);
    assign is_bios  = (idx_q == BIOS_INDEX);

    // Bytes covered by this write, saturated at the RAM depth.
    assign wr_size = in_range
        ? ({1'b0, ioctl.ioctl_addr[AW-1:0]} + 1'b1)
        : FULL;

    // Mirror small images across the whole cart window.
    function automatic logic [AW-1:0] mask_of(logic [AW:0] s);
        if (s != '0 && s <= QTR)
            return QTR[AW-1:0] - 1'b1;
        if (s != '0 && s <= HALF)
            return HALF[AW-1:0] - 1'b1;
        return '1;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        size_d    = size_q;
        present_d = present_q;
        mask_d    = mask_q;
        c_we_d    = 1'b0;
        c_addr_d  = c_addr_q;
        c_data_d  = c_data_q;
        b_we_d    = 1'b0;
        b_addr_d  = b_addr_q;
        b_data_d  = b_data_q;

        if (dl_rise) begin
            // A new download always wins, even mid-fill or mid-hold.
            state_d = S_LOAD;
            idx_d   = ioctl.ioctl_index;
            if (ioctl.ioctl_index == CART_INDEX)
                size_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (ioctl.ioctl_wr && is_cart) begin
                        if (wr_size > size_q)
                            size_d = wr_size;
                        if (in_range) begin
                            c_we_d   = 1'b1;
                            c_addr_d = ioctl.ioctl_addr[AW-1:0];
                            c_data_d = ioctl.ioctl_dout;
                        end
                    end
                    if (ioctl.ioctl_wr && is_bios && in_range) begin
                        b_we_d   = 1'b1;
                        b_addr_d = ioctl.ioctl_addr[AW-1:0];
                        b_data_d = ioctl.ioctl_dout;
                    end
                    if (dl_fall) begin
                        if (is_cart && !size_d[AW]) begin
                            state_d = S_FILL;
                            ptr_d   = size_d[AW-1:0];
                        end else begin
                            state_d = S_HOLD;
                            cnt_d   = '0;
                        end
                    end
                end
                S_FILL: begin
                    c_we_d   = 1'b1;
                    c_addr_d = ptr_q;
                    c_data_d = FILL_BYTE;
                    ptr_d    = ptr_q + 1'b1;
                    if (ptr_q == {AW{1'b1}}) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1))
                        state_d = S_RUN;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
                S_RUN: begin
                end
                default: state_d = S_HOLD;
            endcase
        end

        if (state_d == S_HOLD && state_q != S_HOLD) begin
            present_d = (size_d != '0);
            mask_d    = mask_of(size_d);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= S_HOLD;
            dl_q      <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            size_q    <= '0;
            present_q <= 1'b0;
            mask_q    <= '1;
            run_q     <= 1'b0;
            wait_q    <= 1'b0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            c_data_q  <= '0;
            b_we_q    <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            dl_q      <= ioctl.ioctl_download;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            size_q    <= size_d;
            present_q <= present_d;
            mask_q    <= mask_d;
            run_q     <= (state_d == S_RUN);
            wait_q    <= (state_d == S_FILL) ||
                         (state_d == S_HOLD);
            c_we_q    <= c_we_d;
            c_addr_q  <= c_addr_d;
            c_data_q  <= c_data_d;
            b_we_q    <= b_we_d;
            b_addr_q  <= b_addr_d;
            b_data_q  <= b_data_d;
        end
    end

    assign ioctl.ioctl_wait = wait_q;
    assign sys_reset_l      = run_q;
    assign cart_size        = size_q;
    assign cart_present     = present_q;
    assign cart_ram_we      = c_we_q;
    assign cart_ram_data    = c_data_q;
    assign bios_ram_we      = b_we_q;
    assign bios_ram_data    = b_data_q;
    assign cart_ram_addr    = (state_q == S_RUN)
                            ? (cpu_cart_addr & mask_q)
                            : c_addr_q;
    assign bios_ram_addr    = (state_q == S_RUN)
                            ? cpu_bios_addr
                            : b_addr_q;

endmodule
